// File: rtl/wb_sram_512x32_ctrl.sv
// Wishbone classic slave bridging a 2 KB window onto a 512x32 single-port SRAM
// with active-low enables. Writes ack after one cycle, reads after two.
//
// state | meaning
// IDLE  | waiting for a request; SRAM strobed here on a window hit
// RD    | SRAM read issued, capture ram_q if the cycle is still open
// RESP  | ack or err is high this cycle; no new request accepted
module wb_sram_512x32_ctrl #(
  parameter logic [31:0] BASE_ADR = 32'h0100_0000,
  parameter logic [31:0] ADR_MASK = 32'hFFFF_F800
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        ram_cen,
  output logic        ram_gwen,
  output logic [3:0]  ram_wen,
  output logic [8:0]  ram_a,
  output logic [31:0] ram_d,
  input  logic [31:0] ram_q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic        req;
  logic        hit;
  logic        accept;

  assign req    = wb_cyc_i & wb_stb_i;
  assign hit    = ((wb_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK));
  assign accept = (state_q == IDLE) & req & hit;

  assign ram_a = wb_adr_i[10:2];
  assign ram_d = wb_dat_i;

  // SRAM strobes are gated by resetn so nothing is written while in reset.
  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = 4'hF;
    if (resetn && accept) begin
      ram_cen = 1'b0;
      if (wb_we_i) begin
        ram_gwen = (wb_sel_i == 4'h0);
        ram_wen  = ~wb_sel_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          if (wb_we_i) begin
            state_d = RESP;
            ack_d   = 1'b1;
          end else begin
            state_d = RD;
          end
        end else if (req) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RD: begin
        if (wb_cyc_i) begin
          state_d = RESP;
          ack_d   = 1'b1;
          dat_d   = ram_q;
        end else begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_sram_512x32_ctrl.sv
// Directed bench for wb_sram_512x32_ctrl: write/read latency, byte lanes,
// window miss, aborted read, and reset during a read.
module tb_wb_sram_512x32_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic        ram_cen, ram_gwen;
  logic [3:0]  ram_wen;
  logic [8:0]  ram_a;
  logic [31:0] ram_d;
  logic [31:0] ram_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_sram_512x32_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .ram_cen  (ram_cen),
    .ram_gwen (ram_gwen),
    .ram_wen  (ram_wen),
    .ram_a    (ram_a),
    .ram_d    (ram_d),
    .ram_q    (ram_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_req(input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_adr_i = adr;
    wb_dat_i = dat;
    #1;
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'h0;
  endtask

  initial begin
    resetn   = 1'b0;
    bus_idle();
    wb_adr_i = 32'h0;
    wb_dat_i = 32'h0;
    ram_q    = 32'h0;
    #3;
    chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("rst_err", {31'b0, wb_err_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'h0);
    // hit write on the bus while in reset must not reach the SRAM
    bus_req(1'b1, 4'hF, 32'h0100_0010, 32'h1111_1111);
    chk("rst_cen", {31'b0, ram_cen}, 32'd1);
    chk("rst_gwen", {31'b0, ram_gwen}, 32'd1);
    chk("rst_wen", {28'b0, ram_wen}, 32'hF);
    bus_idle();
    step();
    step();
    resetn = 1'b1;
    step();

    // full-word write
    bus_req(1'b1, 4'hF, 32'h0100_0010, 32'hDEAD_BEEF);
    chk("wr_ram_a", {23'b0, ram_a}, 32'h004);
    chk("wr_ram_d", ram_d, 32'hDEAD_BEEF);
    chk("wr_cen", {31'b0, ram_cen}, 32'd0);
    chk("wr_gwen", {31'b0, ram_gwen}, 32'd0);
    chk("wr_wen", {28'b0, ram_wen}, 32'h0);
    chk("wr_ack_e0", {31'b0, wb_ack_o}, 32'd0);
    step();
    chk("wr_ack", {31'b0, wb_ack_o}, 32'd1);
    chk("wr_err", {31'b0, wb_err_o}, 32'd0);
    chk("wr_resp_cen", {31'b0, ram_cen}, 32'd1);
    bus_idle();
    step();
    chk("wr_ack_drop", {31'b0, wb_ack_o}, 32'd0);
    chk("wr_dat_kept", wb_dat_o, 32'h0);

    // read, latency 2
    ram_q = 32'hDEAD_BEEF;
    bus_req(1'b0, 4'hF, 32'h0100_0010, 32'h0);
    chk("rd_cen", {31'b0, ram_cen}, 32'd0);
    chk("rd_gwen", {31'b0, ram_gwen}, 32'd1);
    chk("rd_wen", {28'b0, ram_wen}, 32'hF);
    step();
    chk("rd_ack_e0", {31'b0, wb_ack_o}, 32'd0);
    chk("rd_state_cen", {31'b0, ram_cen}, 32'd1);
    step();
    chk("rd_ack", {31'b0, wb_ack_o}, 32'd1);
    chk("rd_dat", wb_dat_o, 32'hDEAD_BEEF);
    bus_idle();
    ram_q = 32'h5555_5555;
    step();
    chk("rd_ack_drop", {31'b0, wb_ack_o}, 32'd0);
    chk("rd_dat_hold", wb_dat_o, 32'hDEAD_BEEF);

    // byte lane 2 write, low address bits ignored
    bus_req(1'b1, 4'b0100, 32'h0100_0017, 32'h00AA_0000);
    chk("lane_ram_a", {23'b0, ram_a}, 32'h005);
    chk("lane_wen", {28'b0, ram_wen}, 32'hB);
    chk("lane_gwen", {31'b0, ram_gwen}, 32'd0);
    step();
    chk("lane_ack", {31'b0, wb_ack_o}, 32'd1);
    bus_idle();
    step();

    // empty sel: no write but still acked
    bus_req(1'b1, 4'h0, 32'h0100_0020, 32'h1234_0000);
    chk("nosel_cen", {31'b0, ram_cen}, 32'd0);
    chk("nosel_gwen", {31'b0, ram_gwen}, 32'd1);
    chk("nosel_wen", {28'b0, ram_wen}, 32'hF);
    step();
    chk("nosel_ack", {31'b0, wb_ack_o}, 32'd1);
    chk("wr_no_dat", wb_dat_o, 32'hDEAD_BEEF);
    bus_idle();
    step();

    // window miss
    bus_req(1'b1, 4'hF, 32'h0100_0800, 32'hFFFF_FFFF);
    chk("miss_cen", {31'b0, ram_cen}, 32'd1);
    chk("miss_gwen", {31'b0, ram_gwen}, 32'd1);
    step();
    chk("miss_err", {31'b0, wb_err_o}, 32'd1);
    chk("miss_ack", {31'b0, wb_ack_o}, 32'd0);
    bus_idle();
    step();
    chk("miss_err_drop", {31'b0, wb_err_o}, 32'd0);

    // read aborted in RD, then write straight from IDLE
    ram_q = 32'h1234_5678;
    bus_req(1'b0, 4'hF, 32'h0100_0040, 32'h0);
    step();
    bus_idle();
    step();
    chk("abort_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("abort_dat", wb_dat_o, 32'hDEAD_BEEF);
    bus_req(1'b1, 4'hF, 32'h0100_0044, 32'hCAFE_F00D);
    chk("b2b_cen", {31'b0, ram_cen}, 32'd0);
    chk("b2b_ram_a", {23'b0, ram_a}, 32'h011);
    step();
    chk("b2b_ack", {31'b0, wb_ack_o}, 32'd1);
    bus_idle();
    step();

    // reset pulsed during RD
    ram_q = 32'hA5A5_A5A5;
    bus_req(1'b0, 4'hF, 32'h0100_0010, 32'h0);
    step();
    resetn = 1'b0;
    #1;
    chk("rrd_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("rrd_dat", wb_dat_o, 32'h0);
    chk("rrd_cen", {31'b0, ram_cen}, 32'd1);
    bus_idle();
    step();
    resetn = 1'b1;
    step();
    chk("rrd_ack_after", {31'b0, wb_ack_o}, 32'd0);
    chk("rrd_err_after", {31'b0, wb_err_o}, 32'd0);
    step();
    chk("rrd_ack_after2", {31'b0, wb_ack_o}, 32'd0);
    chk("rrd_dat_after", wb_dat_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
